// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed program image over a byte stream, writes it
// into instruction memory as little-endian 32-bit words and releases the core
// only after the XOR checksum of the payload matches.
// Latency: one write pulse the cycle after each 4th payload byte; core_rst/done
// update the cycle after the checksum byte is accepted.
// Backpressure: rx_ready is high in every loading state and low during RST, RUN
// and ERROR; one byte per cycle is sustained.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   rx_data/valid   incoming byte and its qualifier; rx_ready accepts it
//   imem_we/addr/wdata  instruction memory write port (word addressed)
//   core_rst        holds the core in reset until a good image is loaded
//   done, err       load complete / load failed (sticky until RST)
// Optional feature: define BOOT_TIMEOUT_EN to abort a stalled load after
// TIMEOUT_CYCLES idle cycles in LEN1, PAYLOAD or CHECK.
module imem_boot_loader #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_PAYLOAD, S_CHECK, S_RUN, S_ERROR
  } state_t;

  // Word capacity of the memory, held in 17 bits so a 16-bit length compares cleanly.
  localparam logic [16:0] CAP = 17'(2**ADDR_W);

  generate
    if (ADDR_W < 1 || ADDR_W > 16) begin : g_bad_addr_w
      $error("imem_boot_loader: ADDR_W must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("imem_boot_loader: TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [ADDR_W:0] word_idx_q, word_idx_d;   // one extra bit: reaches N == 2**ADDR_W
  logic [23:0]     buf_q, buf_d;              // lanes 0..2 of the word being built
  logic [7:0]      chk_q, chk_d;
  logic            we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]     wdata_d;
  logic            core_rst_d, done_d, err_d;

  logic            rx_open;
  logic            accept;
  logic [16:0]     len_full;
  logic            to_hit;

  assign rx_open  = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  // Gating with RST keeps a byte presented during reset from being consumed.
  assign rx_ready = rx_open && !RST;
  assign accept   = rx_valid && rx_ready;
  assign len_full = {1'b0, rx_data, len_q[7:0]};

`ifdef BOOT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q, to_d;

  // Every state entry except ERROR happens on an acceptance, so clearing on
  // acceptance (or outside the watched states) also covers state entry.
  always_comb begin
    to_d   = '0;
    to_hit = 1'b0;
    if (rx_open && state_q != S_LEN0 && !accept) begin
      if (to_q == TO_LAST) to_hit = 1'b1;
      else                 to_d   = to_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    buf_d      = buf_q;
    chk_d      = chk_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    core_rst_d = core_rst;
    done_d     = done;
    err_d      = err;

    unique case (state_q)
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if (len_full > CAP) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (len_full == 17'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          chk_d      = chk_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: buf_d[7:0]   = rx_data;
            2'd1: buf_d[15:8]  = rx_data;
            2'd2: buf_d[23:16] = rx_data;
            2'd3: begin
              we_d       = 1'b1;
              addr_d     = word_idx_q[ADDR_W-1:0];
              wdata_d    = {rx_data, buf_q};
              word_idx_d = word_idx_q + 1'b1;
              if (17'(word_idx_q) + 17'd1 == {1'b0, len_q}) state_d = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d    = S_RUN;
            core_rst_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN, S_ERROR: begin
      end
      default: begin
        state_d = S_ERROR;
        err_d   = 1'b1;
      end
    endcase

    if (to_hit) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_LEN0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      buf_q      <= '0;
      chk_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      buf_q      <= buf_d;
      chk_q      <= chk_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_rst   <= core_rst_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed frames plus randomized frames,
// checked against a frame-level reference model.
module tb_imem_boot_loader;
  localparam int AW   = 4;
  localparam int TO   = 16;
  localparam int CAPW = 1 << AW;

  typedef logic [7:0] u8_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RST(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_rst(core_rst), .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = -1, last_we_cyc = -1, done_rise_cyc = -1, fall_cyc = -1, err_rise_cyc = -1;
  logic done_p = 1'b0, core_rst_p = 1'b1, err_p = 1'b0;
  logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  int exp_consumed;
  bit exp_done, exp_err;

  // Observer: samples on the falling edge, between register updates.
  always @(negedge clk) begin
    cyc++;
    if (rx_valid && rx_ready) last_acc_cyc = cyc;
    if (imem_we) begin
      got_addr.push_back(32'(imem_addr));
      got_data.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
    if (done && !done_p) done_rise_cyc = cyc;
    if (!core_rst && core_rst_p) fall_cyc = cyc;
    if (err && !err_p) err_rise_cyc = cyc;
    done_p = done;
    core_rst_p = core_rst;
    err_p = err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    rx_valid = 1'b1;            // byte offered during reset must be discarded
    rx_data = 8'($urandom);
    @(negedge clk);
    check_eq("rdy_in_rst", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rx_valid = 1'b0;
    got_addr.delete();
    got_data.delete();
    last_acc_cyc = -1; last_we_cyc = -1; done_rise_cyc = -1; fall_cyc = -1; err_rise_cyc = -1;
    @(negedge clk);
    check_eq("rst_rdy", 32'(rx_ready), 32'd1);
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_core_rst", 32'(core_rst), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
  endtask

  // Offers bytes in order; gives up after 20 refused offers.
  task automatic send_bytes(input u8_t b[$], input bit gaps, output int n_acc);
    int stall;
    stall = 0;
    n_acc = 0;
    while (n_acc < b.size() && stall < 20) begin
      @(posedge clk); #1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data = b[n_acc];
      end
      @(negedge clk);
      if (rx_valid && rx_ready) n_acc++;
      else if (rx_valid) stall++;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Reference: decode a frame into expected writes and outcome.
  task automatic model(input u8_t f[$]);
    int len;
    logic [7:0] x;
    x = 8'h00;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err = 0;
    len = int'(f[0]) + 256 * int'(f[1]);
    if (len > CAPW) begin
      exp_err = 1;
      exp_consumed = 2;
      return;
    end
    for (int w = 0; w < len; w++) begin
      exp_addr.push_back(32'(w));
      exp_data.push_back({f[2+4*w+3], f[2+4*w+2], f[2+4*w+1], f[2+4*w]});
      for (int k = 0; k < 4; k++) x ^= f[2+4*w+k];
    end
    exp_consumed = 3 + 4 * len;
    if (f[2+4*len] == x) exp_done = 1;
    else exp_err = 1;
  endtask

  task automatic build_frame(input int n, input bit corrupt, output u8_t f[$]);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    f.delete();
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    if (n > CAPW) return;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x ^= b;
    end
    f.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic run_frame(input string tag, input u8_t f[$], input bit gaps);
    u8_t tx[$];
    int n_acc;
    logic [31:0] hold_addr;
    model(f);
    tx = f;
    for (int i = 0; i < 3; i++) tx.push_back(8'($urandom));   // trailing bytes must be refused
    send_bytes(tx, gaps, n_acc);
    repeat (3) @(negedge clk);
    check_eq({tag, "_accepted"}, 32'(n_acc), 32'(exp_consumed));
    check_eq({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    foreach (exp_addr[i]) begin
      if (i < got_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
        check_eq($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      end
    end
    hold_addr = (exp_addr.size() > 0) ? exp_addr[exp_addr.size()-1] : 32'd0;
    check_eq({tag, "_addr_hold"}, 32'(imem_addr), hold_addr);
    check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_core_rst"}, 32'(core_rst), 32'(!exp_done));
    check_eq({tag, "_rdy_after"}, 32'(rx_ready), 32'd0);
    if (exp_done) begin
      check_eq({tag, "_done_lat"}, 32'(done_rise_cyc), 32'(last_acc_cyc + 1));
      check_eq({tag, "_rel_lat"}, 32'(fall_cyc), 32'(last_acc_cyc + 1));
      if (exp_addr.size() > 0)
        check_eq({tag, "_we_before_rel"}, 32'(last_we_cyc < fall_cyc), 32'd1);
    end else begin
      check_eq({tag, "_err_lat"}, 32'(err_rise_cyc), 32'(last_acc_cyc + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    u8_t f[$];
    u8_t part[$];
    int n;
    bit corrupt;
    int n_acc;

    do_reset();
    f = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
    run_frame("tp_ok", f, 1'b0);
    if (got_data.size() == 2) begin
      check_eq("tp_ok_word0", got_data[0], 32'h0000_0013);
      check_eq("tp_ok_word1", got_data[1], 32'h0000_006F);
    end

    do_reset();
    f[10] = 8'h7D;
    run_frame("tp_badchk", f, 1'b0);

    do_reset();
    f = {8'h00, 8'h00, 8'h00};
    run_frame("tp_zero", f, 1'b0);

    do_reset();
    f = {8'h11, 8'h00};
    run_frame("tp_toolong", f, 1'b0);

    do_reset();
    build_frame(CAPW, 1'b0, f);
    run_frame("full_cap", f, 1'b1);
    if (got_addr.size() > 0)
      check_eq("full_cap_last_addr", got_addr[got_addr.size()-1], 32'(CAPW - 1));

    // Reset part-way through a 2-word frame, then load a fresh 1-word frame.
    do_reset();
    build_frame(2, 1'b0, f);
    part = f[0:6];
    send_bytes(part, 1'b0, n_acc);
    do_reset();
    build_frame(1, 1'b0, f);
    run_frame("after_rst", f, 1'b0);

    // Stall after LEN_LO.
    do_reset();
    part = {8'h00};
    send_bytes(part, 1'b0, n_acc);
`ifdef BOOT_TIMEOUT_EN
    repeat (TO + 8) @(negedge clk);
    // Acceptance is logged one falling edge before its clock edge, so the
    // error flag appears TO clock edges after that edge, i.e. TO+1 samples later.
    check_eq("to_err_cyc", 32'(err_rise_cyc), 32'(last_acc_cyc + TO + 1));
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_core_rst", 32'(core_rst), 32'd1);
    check_eq("to_done", 32'(done), 32'd0);
`else
    repeat (1000) @(negedge clk);
    check_eq("nto_err", 32'(err), 32'd0);
    check_eq("nto_rdy", 32'(rx_ready), 32'd1);
    check_eq("nto_done", 32'(done), 32'd0);
    part = {8'h00, 8'h00};   // LEN_HI then checksum of an empty image
    send_bytes(part, 1'b0, n_acc);
    repeat (2) @(negedge clk);
    check_eq("nto_resume_done", 32'(done), 32'd1);
`endif

    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, CAPW);
      if ($urandom_range(0, 7) == 0) n = CAPW + 1 + $urandom_range(0, 300);
      corrupt = ($urandom_range(0, 3) == 0);
      build_frame(n, corrupt, f);
      do_reset();
      run_frame($sformatf("rnd%0d", k), f, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
